i2c_slave_responder: RTL
========================

Name: i2c_slave_responder

Overview:
I2C target (slave) end of the team's I2C link. It answers the master driver's address byte, ACKs on an address match, and then does one of two things. For a read (R/W=1) it returns bytes from its TxData port. For a write (R/W=0) it captures bytes onto ReceivedData. It stands in for the TMP101 in the bench and in loopback FPGA builds, and is clocked by the same 60 MHz system clock as the master.

Parameters:
SlaveAddress, 7'b1001000, 7-bit address this block answers to (default pairs with master FirstByte 8'b10010001).
TxReset, 8'hFF, byte driven when TxData is not valid (TxValid=0) at byte load.

Ports:
clock  input  1  system clock; all logic on posedge.
Reset  input  1  synchronous, active-low reset.
SCL  input  1  I2C clock from master (asynchronous to clock).
SDA  inout  1  I2C data, open-drain: module drives 1'b0 or 1'bz only.
TxData  input  8  byte to send to master on read transfers.
TxValid  input  1  TxData valid; sampled when a TX byte is loaded.
TxLoaded  output  1  one-cycle pulse when TxData is latched into the shift register.
ReceivedData  output  8  last byte written by master.
DataValid  output  1  one-cycle pulse when ReceivedData updates.
AddressMatch  output  1  high from address ACK until STOP or repeated START.
ReadMode  output  1  R/W bit of the current matched transfer.
Busy  output  1  high between START and STOP.

Behaviour:
- Reset (Reset==0 at posedge): every output is 0 and the SDA driver is released (z). The FSM goes to IDLE, the bit counter to 0, and the synchronisers are set to 1.
- Synchronisers: SCL and SDA each pass through a 2-flop synchroniser, plus a 3rd flop for edge detection. Edges take 3 clocks to be seen.
- START: SDA falling while SCL high. STOP: SDA rising while SCL high. Both take priority over data edges and are honoured in every state.
- A START, including a repeated START, forces state ADDR, clears the bit counter, releases SDA and sets Busy=1.
- A STOP forces IDLE, releases SDA, and clears Busy, AddressMatch and ReadMode.
- Bits are sampled on the synchronised SCL rising edge and shifted MSB first. SDA is changed only on the synchronised SCL falling edge.
- FSM states:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. On the 8th rising edge, compare bits[7:1] with SlaveAddress.
    - Match: ReadMode=bit0, AddressMatch=1, go to ADDR_ACK.
    - Mismatch: go to WAIT_STOP, with SDA never driven.
  - ADDR_ACK: on the falling edge after bit 8, drive SDA=0. Hold through the 9th rising edge. On the next falling edge:
    - ReadMode=1: load the shift register with TxData if TxValid, else TxReset. Pulse TxLoaded if TxValid. Drive the MSB and go to TX_BYTE.
    - ReadMode=0: release SDA and go to RX_BYTE.
  - RX_BYTE: shift 8 bits. On the 8th rising edge, update ReceivedData, pulse DataValid for 1 clock and go to RX_ACK.
  - RX_ACK: drive SDA=0 from the next falling edge through the 9th falling edge. Then release SDA and return to RX_BYTE, with no byte limit.
  - TX_BYTE: drive each bit as 0 for a 0 bit and z for a 1 bit, changing on each falling edge. After the 8th bit's falling edge, release SDA and go to TX_ACK.
  - TX_ACK: sample SDA on the 9th rising edge.
    - 0 (ACK): on the next falling edge, reload TxData/TxReset as in ADDR_ACK and go to TX_BYTE.
    - 1 (NACK): go to WAIT_STOP with SDA released.
  - WAIT_STOP: ignore data edges; leave only on STOP (to IDLE) or START (to ADDR).
- The bit counter is 4 bits and wraps to 0 on every byte and ACK boundary.
- ReceivedData holds its value until the next completed write byte.
- Glitches on SCL shorter than 3 clocks are not required to be filtered.

Optional Feature:
I2C_GENERAL_CALL_EN.
- Defined: address 7'b0000000 with R/W=0 is also ACKed. It enters RX_BYTE with AddressMatch=1 and receives bytes normally. Address 0 with R/W=1 is treated as a mismatch.
- Undefined: only SlaveAddress matches; address 0 goes to WAIT_STOP.

Test Plan:
1. Reset low for 2 clocks with SCL=SDA=1 -> all outputs 0 and SDA=z. Then release Reset, assert START and send 8'b10010001 -> SDA low during the 9th SCL pulse, AddressMatch=1, ReadMode=1.
2. Read with TxData=8'hA5 and TxValid=1 -> TxLoaded pulses once, master samples 1010_0101. Master NACK then STOP -> SDA=z and Busy=0.
3. Write 8'b10010000, then 8'h3C, then 8'hC3 -> DataValid pulses twice with ReceivedData 8'h3C then 8'hC3. Each byte is ACKed (SDA=0 on its 9th pulse).
4. Address 8'b10100001 -> no ACK (SDA=z throughout), AddressMatch=0; the block stays silent until STOP.
5. Mid-read with TxValid=0 -> byte 8'hFF is sent. Master ACKs, then a repeated START with 8'b10010000 -> ADDR re-entered, ReadMode=0, next byte captured.
6. Reset driven low mid-RX_ACK while SDA=0 -> on the next posedge SDA=z, the FSM is in IDLE and all outputs are 0. With I2C_GENERAL_CALL_EN defined, address 8'b00000000 is ACKed; without it, the same address is not ACKed.

Source files
------------

// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder: I2C target that ACKs its address, serves reads from TxData and captures writes.
// Optional I2C_GENERAL_CALL_EN also ACKs the general-call address (0, write only).
`timescale 1ns/1ps
module i2c_slave_responder #(
  parameter logic [6:0] SlaveAddress = 7'b1001000,
  parameter logic [7:0] TxReset      = 8'hFF
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic       SCL,
  inout  wire        SDA,
  input  logic [7:0] TxData,
  input  logic       TxValid,
  output logic       TxLoaded,
  output logic [7:0] ReceivedData,
  output logic       DataValid,
  output logic       AddressMatch,
  output logic       ReadMode,
  output logic       Busy
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP} state_t;
  state_t state_q, state_d;
  logic [2:0] scl_q, sda_q;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d, rx_q, rx_d, tx_byte;
  logic drv_q, drv_d, dv_q, dv_d, txl_q, txl_d, am_q, am_d, rm_q, rm_d, busy_q, busy_d;
  logic sda_s, rise, fall, start, stop, match;
  assign sda_s = sda_q[1];
  assign rise  = scl_q[1] & ~scl_q[2];
  assign fall  = ~scl_q[1] & scl_q[2];
  assign start = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
  assign tx_byte = TxValid ? TxData : TxReset;
`ifdef I2C_GENERAL_CALL_EN
  assign match = (sh_q[6:0] == SlaveAddress) | ((sh_q[6:0] == 7'd0) & ~sda_s);
`else
  assign match = sh_q[6:0] == SlaveAddress;
`endif
  // ACK phases use drv_q as the "first falling edge already seen" flag
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    rx_d    = rx_q;
    drv_d   = drv_q;
    dv_d    = 1'b0;
    txl_d   = 1'b0;
    am_d    = am_q;
    rm_d    = rm_q;
    busy_d  = busy_q;
    if (start || stop) begin
      state_d = start ? ADDR : IDLE;
      cnt_d   = 4'd0;
      drv_d   = 1'b0;
      busy_d  = start;
      am_d    = 1'b0;
      rm_d    = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (rise) begin
          sh_d  = {sh_q[6:0], sda_s};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d   = 4'd0;
            state_d = match ? ADDR_ACK : WAIT_STOP;
            am_d    = match;
            rm_d    = match & sda_s;
          end
        end
        ADDR_ACK: if (fall) begin
          if (!drv_q) drv_d = 1'b1;
          else if (rm_q) begin
            sh_d    = tx_byte;
            txl_d   = TxValid;
            drv_d   = ~tx_byte[7];
            state_d = TX_BYTE;
          end else begin
            drv_d   = 1'b0;
            state_d = RX_BYTE;
          end
        end
        RX_BYTE: if (rise) begin
          sh_d  = {sh_q[6:0], sda_s};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d   = 4'd0;
            rx_d    = {sh_q[6:0], sda_s};
            dv_d    = 1'b1;
            state_d = RX_ACK;
          end
        end
        RX_ACK: if (fall) begin
          drv_d   = ~drv_q;
          state_d = drv_q ? RX_BYTE : RX_ACK;
        end
        TX_BYTE: if (fall) begin
          sh_d  = {sh_q[6:0], 1'b0};
          drv_d = ~sh_q[6];
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d   = 4'd0;
            drv_d   = 1'b0;
            state_d = TX_ACK;
          end
        end
        TX_ACK: if (rise) begin
          state_d = sda_s ? WAIT_STOP : TX_ACK;
          cnt_d   = sda_s ? 4'd0 : 4'd1;
        end else if (fall && cnt_q == 4'd1) begin
          sh_d    = tx_byte;
          txl_d   = TxValid;
          drv_d   = ~tx_byte[7];
          cnt_d   = 4'd0;
          state_d = TX_BYTE;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (!Reset) begin
      state_q <= IDLE;
      scl_q   <= 3'b111;
      sda_q   <= 3'b111;
      cnt_q   <= 4'd0;
      sh_q    <= 8'd0;
      rx_q    <= 8'd0;
      drv_q   <= 1'b0;
      dv_q    <= 1'b0;
      txl_q   <= 1'b0;
      am_q    <= 1'b0;
      rm_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      scl_q   <= {scl_q[1:0], SCL};
      sda_q   <= {sda_q[1:0], SDA};
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      drv_q   <= drv_d;
      dv_q    <= dv_d;
      txl_q   <= txl_d;
      am_q    <= am_d;
      rm_q    <= rm_d;
      busy_q  <= busy_d;
    end
  end
  assign SDA          = drv_q ? 1'b0 : 1'bz;
  assign TxLoaded     = txl_q;
  assign ReceivedData = rx_q;
  assign DataValid    = dv_q;
  assign AddressMatch = am_q;
  assign ReadMode     = rm_q;
  assign Busy         = busy_q;
endmodule
